// File: rtl/stage_sequencer.sv
// One-hot stage sequencer: walks NUM_STAGES stage enables per instruction, holds
// the memory stage on stall, and supports halt/resume, a stall watchdog and counters.
module stage_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int MEM_STAGE  = 3,
  parameter int CNT_W      = 32,
  parameter int WAIT_LIMIT = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          halt_req,
  input  logic                          stall,
  output logic [NUM_STAGES-1:0]         stage_en,
  output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
  output logic                          instr_done,
  output logic                          busy,
  output logic [CNT_W-1:0]              retired_count,
  output logic [CNT_W-1:0]              stall_count,
  output logic                          timeout_err
);

  localparam int IDX_W  = $clog2(NUM_STAGES);
  localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0]  MEM_IDX   = IDX_W'(MEM_STAGE);
  localparam logic [WCNT_W-1:0] LIMIT_VAL = WCNT_W'(WAIT_LIMIT);

  typedef enum logic [1:0] {IDLE, RUN, STALL, HALTED} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [NUM_STAGES-1:0] en_reg, en_next;
  logic               done_reg, done_next;
  logic               busy_reg, busy_next;
  logic [CNT_W-1:0]   retired_reg, retired_next;
  logic [CNT_W-1:0]   stall_cnt_reg, stall_cnt_next;
  logic               timeout_reg, timeout_next;
  logic [WCNT_W-1:0]  wait_reg, wait_next;

  logic               running, at_last, at_mem;
  logic               stall_hit, advance, retire, trip, launch;
  logic [WCNT_W-1:0]  wait_inc;

  assign running   = (state_reg == RUN) || (state_reg == STALL);
  assign at_last   = (idx_reg == LAST_IDX);
  assign at_mem    = (idx_reg == MEM_IDX);
  assign stall_hit = running && at_mem && stall;
  assign advance   = running && !stall_hit;
  assign retire    = advance && at_last;
  assign launch    = !running && start;
  // The consecutive-stall run counts the entry cycle, so it restarts at 1 from RUN.
  assign wait_inc  = ((state_reg == STALL) ? wait_reg : '0) + WCNT_W'(1);
  assign trip      = stall_hit && (wait_inc >= LIMIT_VAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      en_reg        <= '0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      retired_reg   <= '0;
      stall_cnt_reg <= '0;
      timeout_reg   <= 1'b0;
      wait_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      en_reg        <= en_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
      retired_reg   <= retired_next;
      stall_cnt_reg <= stall_cnt_next;
      timeout_reg   <= timeout_next;
      wait_reg      <= wait_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, HALTED: begin
        if (start) state_next = RUN;
      end
      RUN, STALL: begin
        if (stall_hit)
          state_next = trip ? HALTED : STALL;
        else if (retire && halt_req)
          state_next = HALTED;
        else
          state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    idx_next       = idx_reg;
    done_next      = retire;
    wait_next      = stall_hit ? wait_inc : '0;
    retired_next   = retired_reg + (retire ? CNT_W'(1) : CNT_W'(0));
    stall_cnt_next = stall_cnt_reg;
    timeout_next   = timeout_reg;
    busy_next      = (state_next == RUN) || (state_next == STALL);

    if (launch) begin
      idx_next     = '0;
      timeout_next = 1'b0;
    end else if (advance) begin
      idx_next = at_last ? '0 : idx_reg + IDX_W'(1);
    end
    if (stall_hit && (stall_cnt_reg != {CNT_W{1'b1}}))
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    if (trip)
      timeout_next = 1'b1;
    if (state_next == HALTED)
      idx_next = '0;
  end

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_onehot
      assign en_next[gi] = busy_next && (idx_next == IDX_W'(gi));
    end
  endgenerate

  assign stage_en      = en_reg;
  assign stage_idx     = idx_reg;
  assign instr_done    = done_reg;
  assign busy          = busy_reg;
  assign retired_count = retired_reg;
  assign stall_count   = stall_cnt_reg;
  assign timeout_err   = timeout_reg;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench: two sequencer builds (5-stage and 3-stage) share random and
// directed stimulus; a per-instruction reference model predicts every cycle.
module tb_stage_sequencer;

  localparam int M_IDLE = 0, M_RUN = 1, M_STALL = 2, M_HALT = 3;

  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, halt_req = 1'b0, stall = 1'b0;

  logic [4:0] en0;  logic [2:0] idx0;
  logic done0, busy0, tout0;  logic [7:0] ret0, stl0;
  logic [2:0] en1;  logic [1:0] idx1;
  logic done1, busy1, tout1;  logic [7:0] ret1, stl1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  stage_sequencer #(.NUM_STAGES(5), .MEM_STAGE(3), .CNT_W(8), .WAIT_LIMIT(4)) dut0 (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .stall(stall),
    .stage_en(en0), .stage_idx(idx0), .instr_done(done0), .busy(busy0),
    .retired_count(ret0), .stall_count(stl0), .timeout_err(tout0));

  stage_sequencer #(.NUM_STAGES(3), .MEM_STAGE(1), .CNT_W(8), .WAIT_LIMIT(6)) dut1 (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .stall(stall),
    .stage_en(en1), .stage_idx(idx1), .instr_done(done1), .busy(busy1),
    .retired_count(ret1), .stall_count(stl1), .timeout_err(tout1));

  typedef struct {
    int mode; int idx; int wt; int ret; int stl; bit tout; bit done;
  } model_t;

  typedef struct {
    logic [15:0] en; int idx; bit done; bit busy; int ret; int stl; bit tout;
  } exp_t;

  model_t m0, m1;
  exp_t   q0[$], q1[$];

  // Instruction-level behaviour: a position within the instruction plus a stall run.
  function automatic model_t step(model_t m, bit r, bit s, bit h, bit st,
                                  int ns, int mem, int lim, int cmax);
    model_t n = m;
    n.done = 0;
    if (r) begin
      n = '{M_IDLE, 0, 0, 0, 0, 0, 0};
    end else if (m.mode == M_IDLE || m.mode == M_HALT) begin
      if (s) begin n.mode = M_RUN; n.idx = 0; n.tout = 0; end
    end else if (st && m.idx == mem) begin
      n.stl = (m.stl < cmax) ? m.stl + 1 : cmax;
      n.wt  = (m.mode == M_STALL) ? m.wt + 1 : 1;
      if (n.wt >= lim) begin
        n.tout = 1; n.mode = M_HALT; n.idx = 0; n.wt = 0;
      end else begin
        n.mode = M_STALL;
      end
    end else begin
      n.wt = 0;
      if (m.idx == ns - 1) begin
        n.ret = (m.ret + 1) % (cmax + 1);
        n.done = 1; n.idx = 0;
        n.mode = h ? M_HALT : M_RUN;
      end else begin
        n.idx = m.idx + 1; n.mode = M_RUN;
      end
    end
    return n;
  endfunction

  function automatic exp_t expect_of(model_t m);
    exp_t e;
    e.busy = (m.mode == M_RUN || m.mode == M_STALL);
    e.en   = e.busy ? (16'd1 << m.idx) : 16'd0;
    e.idx  = m.idx; e.done = m.done; e.ret = m.ret; e.stl = m.stl; e.tout = m.tout;
    return e;
  endfunction

  task automatic cyc(input bit r, input bit s, input bit h, input bit st);
    @(negedge clk);
    reset = r; start = s; halt_req = h; stall = st;
    m0 = step(m0, r, s, h, st, 5, 3, 4, 255);
    m1 = step(m1, r, s, h, st, 3, 1, 6, 255);
    q0.push_back(expect_of(m0));
    q1.push_back(expect_of(m1));
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic wait_stage(input int target);
    int n = 0;
    while (!(m0.mode == M_RUN && m0.idx == target) && n < 40) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    checks++;
    if (n >= 40) begin
      fails++;
      $display("FAIL wait_stage: actual idx=%0d required=%0d", m0.idx, target);
    end
  endtask

  // Monitor: pops one prediction per DUT each cycle once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("d0_stage_en",   32'(en0),   32'(e.en));
        chk("d0_stage_idx",  32'(idx0),  32'(e.idx));
        chk("d0_instr_done", 32'(done0), 32'(e.done));
        chk("d0_busy",       32'(busy0), 32'(e.busy));
        chk("d0_retired",    32'(ret0),  32'(e.ret));
        chk("d0_stall_cnt",  32'(stl0),  32'(e.stl));
        chk("d0_timeout",    32'(tout0), 32'(e.tout));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d1_stage_en",   32'(en1),   32'(e.en));
        chk("d1_stage_idx",  32'(idx1),  32'(e.idx));
        chk("d1_instr_done", 32'(done1), 32'(e.done));
        chk("d1_busy",       32'(busy1), 32'(e.busy));
        chk("d1_retired",    32'(ret1),  32'(e.ret));
        chk("d1_stall_cnt",  32'(stl1),  32'(e.stl));
        chk("d1_timeout",    32'(tout1), 32'(e.tout));
      end
    end
  end

  initial begin
    m0 = '{M_IDLE, 0, 0, 0, 0, 0, 0};
    m1 = m0;
    repeat (2) cyc(1, 0, 0, 0);
    // two plain instructions
    cyc(0, 1, 0, 0);
    repeat (11) cyc(0, 0, 0, 0);
    // three-cycle memory stall
    wait_stage(3);
    repeat (3) cyc(0, 0, 0, 1);
    repeat (8) cyc(0, 0, 0, 0);
    // watchdog trip, then restart
    wait_stage(3);
    repeat (5) cyc(0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    // halt mid-instruction, then resume
    wait_stage(1);
    repeat (8) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    repeat (6) cyc(0, 0, 0, 0);
    // stall off the memory stage and start while busy are both ignored
    wait_stage(2);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 0);
    repeat (6) cyc(0, 0, 0, 0);
    // reset in the middle of a stall, then a fresh start
    wait_stage(3);
    repeat (2) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 1, 0, 0);
    repeat (12) cyc(0, 0, 0, 0);
    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(199) == 0, $urandom_range(7) == 0,
          $urandom_range(15) == 0, $urandom_range(1) == 1);
    // long reset-free stretch to reach counter wrap and saturation
    for (int i = 0; i < 2500; i++)
      cyc(0, $urandom_range(2) == 0, $urandom_range(39) == 0, $urandom_range(1) == 1);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", q0.size() + q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
